addr_sequencer: RTL and testbench

- Micro-sequencer driving the control inputs of the 16-bit address register file (PC, SP, AR) and the memory strobes.
- Accepts one address-side command at a time over a valid/ready handshake and expands it into 1–3 cycles of RegSel/FunSel/OutCSel/OutDSel steps.
- Tracks stack depth so push/pop faults never reach the ARF.

---
 rtl/addr_sequencer_if.sv | 42 ++++
 rtl/addr_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_addr_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/addr_sequencer_if.sv
// addr_sequencer_if: command handshake, memory strobes and ARF control bundle
// for the address-side micro-sequencer.
//
// Signals
//   cmd_valid / cmd_ready   command handshake (ready high only while idle)
//   cmd_op[2:0]             opcode, sampled on accept
//   cmd_addr[15:0]          load value for CALL/LDAR/SPINIT
//   mem_rdata[15:0]         combinational memory read data (valid with mem_rd)
//   RegSel[2:0]             ARF enables, one-hot: bit2 PC, bit1 SP, bit0 AR
//   FunSel[1:0]             ARF function: 00 dec, 01 inc, 10 load, 11 clear
//   OutCSel / OutDSel       ARF C / D output mux: 00 PC, 01 SP, 1x AR
//   ARF_I[15:0]             ARF load data
//   mem_rd / mem_wr         memory strobes (write data is ARF OutC)
//   done / err              completion / rejection pulses
//
// Modports: master = command issuer and memory side, slave = sequencer.
interface addr_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_addr;
    logic [15:0] mem_rdata;
    logic [2:0]  RegSel;
    logic [1:0]  FunSel;
    logic [1:0]  OutCSel;
    logic [1:0]  OutDSel;
    logic [15:0] ARF_I;
    logic        mem_rd;
    logic        mem_wr;
    logic        done;
    logic        err;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, mem_rdata,
        input  cmd_ready, RegSel, FunSel, OutCSel, OutDSel, ARF_I, mem_rd, mem_wr, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, mem_rdata,
        output cmd_ready, RegSel, FunSel, OutCSel, OutDSel, ARF_I, mem_rd, mem_wr, done, err
    );
endinterface

// File: rtl/addr_sequencer.sv
// addr_sequencer: expands one address-side command (NOP, FETCH, PUSH, POP,
// CALL, RET, LDAR, SPINIT) into 1-3 cycles of ARF control steps plus memory
// strobes. Full-descending stack; SP points at the last pushed word.
//
// Ports
//   Clock   system clock, rising edge
//   Reset   synchronous, active-high
//   bus     addr_sequencer_if.slave (handshake, ARF controls, memory strobes)
//
// Parameters
//   STACK_DEPTH  maximum stack entries (depth counter range 0..STACK_DEPTH)
//
// Configuration macro ADDR_SEQ_STACK_CHECK_EN: when defined, a depth counter
// rejects overflowing PUSH/CALL and underflowing POP/RET with a one-cycle err
// pulse; when undefined, stack commands always execute and err stays low.
module addr_sequencer #(
    parameter int unsigned STACK_DEPTH = 16
) (
    input logic             Clock,
    input logic             Reset,
    addr_sequencer_if.slave bus
);

    typedef enum logic [4:0] {
        StIdle, StNopDone,
        StFRd, StFInc,
        StPDec, StPWr,
        StQRd, StQInc,
        StCDec, StCWr, StCLd,
        StRRd, StRLd, StRInc,
        StALd, StSLd,
        StErr
    } state_e;

    typedef struct packed {
        logic [2:0] reg_sel;
        logic [1:0] fun_sel;
        logic [1:0] out_c_sel;
        logic [1:0] out_d_sel;
        logic       mem_rd;
        logic       mem_wr;
        logic       done;
        logic       err;
    } out_t;

    // Per-state output pattern; outputs are registered from the next state so
    // they line up with the state register without a decode stage after it.
    function automatic out_t decode(state_e s);
        out_t o;
        o = '0;
        case (s)
            StNopDone: o.done = 1'b1;
            StFRd:     begin o.out_d_sel = 2'b00; o.mem_rd = 1'b1; end
            StFInc:    begin o.reg_sel = 3'b100; o.fun_sel = 2'b01; o.done = 1'b1; end
            StPDec:    begin o.reg_sel = 3'b010; o.fun_sel = 2'b00; end
            StPWr:     begin o.out_d_sel = 2'b01; o.mem_wr = 1'b1; o.done = 1'b1; end
            StQRd:     begin o.out_d_sel = 2'b01; o.mem_rd = 1'b1; end
            StQInc:    begin o.reg_sel = 3'b010; o.fun_sel = 2'b01; o.done = 1'b1; end
            StCDec:    begin o.reg_sel = 3'b010; o.fun_sel = 2'b00; end
            StCWr:     begin
                o.out_d_sel = 2'b01;
                o.out_c_sel = 2'b00;
                o.mem_wr    = 1'b1;
            end
            StCLd:     begin o.reg_sel = 3'b100; o.fun_sel = 2'b10; o.done = 1'b1; end
            StRRd:     begin o.out_d_sel = 2'b01; o.mem_rd = 1'b1; end
            StRLd:     begin o.reg_sel = 3'b100; o.fun_sel = 2'b10; end
            StRInc:    begin o.reg_sel = 3'b010; o.fun_sel = 2'b01; o.done = 1'b1; end
            StALd:     begin o.reg_sel = 3'b001; o.fun_sel = 2'b10; o.done = 1'b1; end
            StSLd:     begin o.reg_sel = 3'b010; o.fun_sel = 2'b10; o.done = 1'b1; end
            StErr:     o.err = 1'b1;
            default:   o = '0;
        endcase
        return o;
    endfunction

    state_e      state_q, state_d;
    out_t        out_q, out_d;
    logic [15:0] arf_i_q, arf_i_d;
    logic        accept;
    logic        stack_fault;

    assign bus.cmd_ready = (state_q == StIdle) && !Reset;
    assign accept        = bus.cmd_valid && bus.cmd_ready;

`ifdef ADDR_SEQ_STACK_CHECK_EN
    localparam int unsigned DepthW = $clog2(STACK_DEPTH + 1);

    logic [DepthW-1:0] depth_q, depth_d;

    always_comb begin
        stack_fault = 1'b0;
        unique case (bus.cmd_op)
            3'b010, 3'b100: stack_fault = (depth_q == DepthW'(STACK_DEPTH));
            3'b011, 3'b101: stack_fault = (depth_q == '0);
            default:        stack_fault = 1'b0;
        endcase
    end

    // Depth moves on the edge leaving a command's final step; the fault check
    // at accept keeps it inside 0..STACK_DEPTH.
    always_comb begin
        depth_d = depth_q;
        case (state_q)
            StPWr, StCLd:  depth_d = depth_q + DepthW'(1);
            StQInc, StRInc: depth_d = depth_q - DepthW'(1);
            StSLd:         depth_d = '0;
            default:       depth_d = depth_q;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end
`else
    assign stack_fault = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (stack_fault) begin
                        state_d = StErr;
                    end else begin
                        unique case (bus.cmd_op)
                            3'b000: state_d = StNopDone;
                            3'b001: state_d = StFRd;
                            3'b010: state_d = StPDec;
                            3'b011: state_d = StQRd;
                            3'b100: state_d = StCDec;
                            3'b101: state_d = StRRd;
                            3'b110: state_d = StALd;
                            3'b111: state_d = StSLd;
                            default: state_d = StIdle;
                        endcase
                    end
                end
            end
            StFRd:  state_d = StFInc;
            StPDec: state_d = StPWr;
            StQRd:  state_d = StQInc;
            StCDec: state_d = StCWr;
            StCWr:  state_d = StCLd;
            StRRd:  state_d = StRLd;
            StRLd:  state_d = StRInc;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        out_d   = decode(state_d);
        arf_i_d = arf_i_q;
        if (accept) begin
            arf_i_d = bus.cmd_addr;
        end else if (state_q == StRRd) begin
            // Return address arrives combinationally with mem_rd in R_RD.
            arf_i_d = bus.mem_rdata;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= StIdle;
            out_q   <= '0;
            arf_i_q <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            arf_i_q <= arf_i_d;
        end
    end

    assign bus.RegSel  = out_q.reg_sel;
    assign bus.FunSel  = out_q.fun_sel;
    assign bus.OutCSel = out_q.out_c_sel;
    assign bus.OutDSel = out_q.out_d_sel;
    assign bus.mem_rd  = out_q.mem_rd;
    assign bus.mem_wr  = out_q.mem_wr;
    assign bus.done    = out_q.done;
    assign bus.err     = out_q.err;
    assign bus.ARF_I   = arf_i_q;

endmodule

// File: tb/tb_addr_sequencer.sv
module tb_addr_sequencer;
    localparam int unsigned StackDepth = 16;
`ifdef ADDR_SEQ_STACK_CHECK_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    addr_sequencer_if bus ();

    addr_sequencer #(
        .STACK_DEPTH(StackDepth)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    // Memory model: read data only valid while mem_rd is asserted.
    logic [15:0] rdata_val;
    assign bus.mem_rdata = bus.mem_rd ? rdata_val : 16'hDEAD;

    typedef struct packed {
        logic [2:0]  rs;
        logic [1:0]  fs;
        logic [1:0]  oc;
        logic        oc_care;
        logic [1:0]  od;
        logic [15:0] arf;
        logic        rd;
        logic        wr;
        logic        dn;
        logic        er;
    } step_t;

    step_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    depth_m = 0;
    int    step_no = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_step(input logic [2:0] rs, input logic [1:0] fs, input logic [1:0] od,
                            input logic oc_care, input logic [15:0] arf,
                            input logic rd, input logic wr, input logic dn, input logic er);
        step_t s;
        s.rs = rs; s.fs = fs; s.oc = 2'b00; s.oc_care = oc_care; s.od = od;
        s.arf = arf; s.rd = rd; s.wr = wr; s.dn = dn; s.er = er;
        exp_q.push_back(s);
    endtask

    // Expected step table per opcode, with the bench's own stack-depth model.
    task automatic expect_cmd(input logic [2:0] op, input logic [15:0] addr);
        bit fault;
        fault = 1'b0;
        if (ChkEn && (op == 3'b010 || op == 3'b100) && depth_m == StackDepth) fault = 1'b1;
        if (ChkEn && (op == 3'b011 || op == 3'b101) && depth_m == 0) fault = 1'b1;
        if (fault) begin
            exp_step(3'b000, 2'b00, 2'b00, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        end else begin
            case (op)
                3'b000: exp_step(3'b000, 2'b00, 2'b00, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
                3'b001: begin
                    exp_step(3'b000, 2'b00, 2'b00, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
                    exp_step(3'b100, 2'b01, 2'b00, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
                end
                3'b010: begin
                    exp_step(3'b010, 2'b00, 2'b00, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
                    exp_step(3'b000, 2'b00, 2'b01, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0);
                    depth_m++;
                end
                3'b011: begin
                    exp_step(3'b000, 2'b00, 2'b01, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
                    exp_step(3'b010, 2'b01, 2'b00, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
                    depth_m--;
                end
                3'b100: begin
                    exp_step(3'b010, 2'b00, 2'b00, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
                    exp_step(3'b000, 2'b00, 2'b01, 1'b1, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
                    exp_step(3'b100, 2'b10, 2'b00, 1'b0, addr, 1'b0, 1'b0, 1'b1, 1'b0);
                    depth_m++;
                end
                3'b101: begin
                    exp_step(3'b000, 2'b00, 2'b01, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
                    exp_step(3'b100, 2'b10, 2'b00, 1'b0, rdata_val, 1'b0, 1'b0, 1'b0, 1'b0);
                    exp_step(3'b010, 2'b01, 2'b00, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
                    depth_m--;
                end
                3'b110: exp_step(3'b001, 2'b10, 2'b00, 1'b0, addr, 1'b0, 1'b0, 1'b1, 1'b0);
                default: begin
                    exp_step(3'b010, 2'b10, 2'b00, 1'b0, addr, 1'b0, 1'b0, 1'b1, 1'b0);
                    depth_m = 0;
                end
            endcase
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [15:0] addr);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (bus.cmd_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(posedge Clock); #1;
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: cmd_ready got 0 expected 1 (op %b)", op);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        @(posedge Clock); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20; k++) begin
            if (bus.cmd_ready === 1'b1) return;
            @(posedge Clock); #1;
        end
        n_tests++;
        n_fail++;
        $display("FAIL idle_timeout: cmd_ready got 0 expected 1");
    endtask

    task automatic run(input logic [2:0] op, input logic [15:0] addr);
        expect_cmd(op, addr);
        issue(op, addr);
        wait_idle();
    endtask

    // Monitor: every cycle with any ARF/memory/status activity must match the
    // next expected step.
    step_t mon_e;
    bit    mon_ok;
    initial begin
        forever begin
            @(negedge Clock);
            if (bus.RegSel != 3'b000 || bus.mem_rd || bus.mem_wr || bus.done || bus.err) begin
                n_tests++;
                step_no++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_step %0d: got RegSel=%b rd=%b wr=%b done=%b err=%b expected no activity",
                             step_no, bus.RegSel, bus.mem_rd, bus.mem_wr, bus.done, bus.err);
                end else begin
                    mon_e  = exp_q.pop_front();
                    mon_ok = (bus.RegSel === mon_e.rs) && (bus.mem_rd === mon_e.rd) &&
                             (bus.mem_wr === mon_e.wr) && (bus.done === mon_e.dn) &&
                             (bus.err === mon_e.er);
                    if (mon_e.rs != 3'b000) mon_ok = mon_ok && (bus.FunSel === mon_e.fs);
                    if (mon_e.rd || mon_e.wr) mon_ok = mon_ok && (bus.OutDSel === mon_e.od);
                    if (mon_e.oc_care) mon_ok = mon_ok && (bus.OutCSel === mon_e.oc);
                    if (mon_e.rs != 3'b000 && mon_e.fs == 2'b10)
                        mon_ok = mon_ok && (bus.ARF_I === mon_e.arf);
                    if (!mon_ok) begin
                        n_fail++;
                        $display("FAIL step %0d: got RegSel=%b FunSel=%b OutC=%b OutD=%b ARF_I=%h rd=%b wr=%b done=%b err=%b expected RegSel=%b FunSel=%b OutD=%b ARF_I=%h rd=%b wr=%b done=%b err=%b",
                                 step_no, bus.RegSel, bus.FunSel, bus.OutCSel, bus.OutDSel,
                                 bus.ARF_I, bus.mem_rd, bus.mem_wr, bus.done, bus.err,
                                 mon_e.rs, mon_e.fs, mon_e.od, mon_e.arf, mon_e.rd, mon_e.wr,
                                 mon_e.dn, mon_e.er);
                    end
                end
            end
        end
    end

    initial begin
        Reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'b000;
        bus.cmd_addr  = 16'h0;
        rdata_val     = 16'h0042;

        // Reset state
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        chk("rst_ready", {31'b0, bus.cmd_ready}, 32'd0);
        chk("rst_regsel", {29'b0, bus.RegSel}, 32'd0);
        chk("rst_arf_i", {16'b0, bus.ARF_I}, 32'd0);
        chk("rst_strobes", {28'b0, bus.mem_rd, bus.mem_wr, bus.done, bus.err}, 32'd0);
        @(posedge Clock); #1;
        Reset = 1'b0;
        #1;
        chk("ready_after_rst", {31'b0, bus.cmd_ready}, 32'd1);
        @(posedge Clock); #1;

        // SPINIT then FETCH
        run(3'b111, 16'h0400);
        run(3'b001, 16'h0000);

        // CALL then RET
        run(3'b100, 16'h1234);
        run(3'b101, 16'h9999);

        // POP on an empty stack
        expect_cmd(3'b011, 16'h0000);
        issue(3'b011, 16'h0000);
        @(posedge Clock); #1;
        chk("ready_after_pop_empty", {31'b0, bus.cmd_ready}, ChkEn ? 32'd1 : 32'd0);
        wait_idle();

        // Fill the stack, one more PUSH, then a POP
        run(3'b111, 16'h0800);
        for (int i = 0; i < StackDepth + 1; i++) run(3'b010, 16'h0000);
        run(3'b011, 16'h0000);

        // Reset during C_WR
        exp_step(3'b010, 2'b00, 2'b00, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_step(3'b000, 2'b00, 2'b01, 1'b1, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(3'b100, 16'h2222);
        @(posedge Clock); #1;
        Reset = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        chk("abort_regsel", {29'b0, bus.RegSel}, 32'd0);
        chk("abort_mem_wr", {31'b0, bus.mem_wr}, 32'd0);
        chk("abort_done", {31'b0, bus.done}, 32'd0);
        chk("abort_ready", {31'b0, bus.cmd_ready}, 32'd0);
        @(posedge Clock); #1;
        Reset   = 1'b0;
        depth_m = 0;
        run(3'b011, 16'h0000);

        // cmd_valid held high across a FETCH
        expect_cmd(3'b001, 16'h0000);
        expect_cmd(3'b110, 16'h5555);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'b001;
        bus.cmd_addr  = 16'h0000;
        @(posedge Clock); #1;
        bus.cmd_op   = 3'b110;
        bus.cmd_addr = 16'h5555;
        chk("held_ready_f_rd", {31'b0, bus.cmd_ready}, 32'd0);
        @(posedge Clock); #1;
        chk("held_ready_f_inc", {31'b0, bus.cmd_ready}, 32'd0);
        @(posedge Clock); #1;
        chk("held_ready_idle", {31'b0, bus.cmd_ready}, 32'd1);
        @(posedge Clock); #1;
        bus.cmd_valid = 1'b0;
        wait_idle();

        repeat (3) @(posedge Clock);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
